// File: rtl/wrr_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wrr_sched_pkg                                                   |
// | Purpose  : Shared types and helpers for the weighted round-robin bus       |
// |            scheduler: FSM state encoding, index-width helper and the       |
// |            supported requester-count range.                                |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package wrr_sched_pkg;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Width of a requester index; never below 1 so vectors stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_priority_pick                                                |
// | Purpose  : Combinational rotating-priority picker. Scans the eligible      |
// |            vector starting just after last_i and wrapping modulo N_REQ,   |
// |            returning the first eligible requester.                         |
// | Ports    : elig_i   [N_REQ]  eligible requesters                           |
// |            last_i   [ID_W]   most recently served requester                |
// |            found_o           at least one requester eligible               |
// |            idx_o    [ID_W]   index of the chosen requester                 |
// |            onehot_o [N_REQ]  one-hot form of idx_o (0 when !found_o)       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [ID_W-1:0]  last_i,
  output logic             found_o,
  output logic [ID_W-1:0]  idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  int              cand;
  logic [ID_W-1:0] cand_id;

  // k runs 1..N_REQ so the last-served requester is visited last.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = 0;
    cand_id  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand    = (int'(last_i) + k) % N_REQ;
      cand_id = ID_W'(cand);
      if (!found_o && elig_i[cand_id]) begin
        found_o           = 1'b1;
        idx_o             = cand_id;
        onehot_o[cand_id] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wrr_bus_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wrr_bus_scheduler                                               |
// | Purpose  : Weighted round-robin arbiter for one shared bus. Each requester |
// |            receives up to weight[i] transactions per round; the grant is   |
// |            held until the granted agent pulses end_txn.                    |
// | Macro    : WRR_WATCHDOG_EN - enables the grant watchdog (tmo_limit_i,      |
// |            tmo_event_o). Undefined: tmo_event_o is constant 0.             |
// | Ports    : clk, rstb (async, active-low)                                   |
// |            req_i        [N_REQ]        level request per agent             |
// |            end_txn_i    [N_REQ]        end-of-transaction pulse per agent  |
// |            cfg_load_i                  load weight_cfg_i                   |
// |            weight_cfg_i [N_REQ*WGT_W]  packed weights                      |
// |            tmo_limit_i  [TMO_W]        watchdog limit, 0 = off             |
// |            grant_o      [N_REQ]        registered one-hot grant            |
// |            grant_id_o   [clog2(N_REQ)] granted index                       |
// |            busy_o                      grant active                        |
// |            tmo_event_o                 one-cycle forced-release pulse      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wrr_bus_scheduler
  import wrr_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WGT_W   = 4,
  parameter int DEF_WGT = 1,
  parameter int TMO_W   = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         end_txn_i,
  input  logic                     cfg_load_i,
  input  logic [N_REQ*WGT_W-1:0]   weight_cfg_i,
  input  logic [TMO_W-1:0]         tmo_limit_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     busy_o,
  output logic                     tmo_event_o
);

  localparam int ID_W = id_width(N_REQ);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic              tmo_event_q, tmo_event_d;
  logic [WGT_W-1:0]  weight_q [N_REQ];
  logic [WGT_W-1:0]  weight_d [N_REQ];
  logic [WGT_W-1:0]  credit_q [N_REQ];
  logic [WGT_W-1:0]  credit_d [N_REQ];
  logic [WGT_W-1:0]  cfg_wgt  [N_REQ];

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  wgt_req;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic              cur_end;
  logic              tmo_fire;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign cfg_wgt[gi] = weight_cfg_i[gi*WGT_W +: WGT_W];
      assign elig[gi]    = req_i[gi] & (credit_q[gi] != '0) & (weight_q[gi] != '0);
      // Requests that could be served after a reload; weight-0 agents never count.
      assign wgt_req[gi] = req_i[gi] & (weight_q[gi] != '0);
    end
  endgenerate

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .elig_i   (elig),
    .last_i   (last_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  assign cur_end = end_txn_i[gid_q];

`ifdef WRR_WATCHDOG_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE) begin
      if (pick_found) tmo_cnt_d = '0;
    end else if (tmo_cnt_q != '1) begin
      // Saturate rather than wrap if tmo_limit_i is raised mid-transaction.
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo_fire = (state_q == ST_GRANT) && (tmo_limit_i != '0) &&
                    (tmo_cnt_q == tmo_limit_i - TMO_W'(1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo_limit;
  assign unused_tmo_limit = ^tmo_limit_i;
  assign tmo_fire         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gid_d       = gid_q;
    last_d      = last_q;
    tmo_event_d = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      weight_d[i] = cfg_load_i ? cfg_wgt[i] : weight_q[i];
      credit_d[i] = credit_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d            = ST_GRANT;
          grant_d            = pick_onehot;
          gid_d              = pick_idx;
          credit_d[pick_idx] = credit_q[pick_idx] - WGT_W'(1);
        end else if (|wgt_req) begin
          // Round boundary: weight_d already reflects a coincident cfg_load.
          for (int i = 0; i < N_REQ; i++) credit_d[i] = weight_d[i];
        end
      end
      ST_GRANT: begin
        if (cur_end || tmo_fire) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          last_d      = gid_q;
          tmo_event_d = ~cur_end;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gid_q       <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      tmo_event_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        weight_q[i] <= WGT_W'(DEF_WGT);
        credit_q[i] <= WGT_W'(DEF_WGT);
      end
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gid_q       <= gid_d;
      last_q      <= last_d;
      tmo_event_q <= tmo_event_d;
      for (int i = 0; i < N_REQ; i++) begin
        weight_q[i] <= weight_d[i];
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign grant_o     = grant_q;
  assign grant_id_o  = gid_q;
  assign busy_o      = (state_q == ST_GRANT);
  assign tmo_event_o = tmo_event_q;

endmodule
`default_nettype wire

// File: tb/tb_wrr_bus_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_wrr_bus_scheduler                                            |
// | Purpose  : Self-checking bench for wrr_bus_scheduler. Expected grant order |
// |            is queued as stimulus is applied and checked by a monitor each  |
// |            time a new grant appears; scenario tasks check the rest inline. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wrr_bus_scheduler;

  localparam int N_REQ = 4;
  localparam int WGT_W = 4;
  localparam int TMO_W = 8;

  logic                   clk = 1'b0;
  logic                   rstb = 1'b0;
  logic [N_REQ-1:0]       req_i = '0;
  logic [N_REQ-1:0]       end_txn_i = '0;
  logic                   cfg_load_i = 1'b0;
  logic [N_REQ*WGT_W-1:0] weight_cfg_i = '0;
  logic [TMO_W-1:0]       tmo_limit_i = '0;
  logic [N_REQ-1:0]       grant_o;
  logic [1:0]             grant_id_o;
  logic                   busy_o;
  logic                   tmo_event_o;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  int mon_e;
  logic [N_REQ-1:0] prev_grant = '0;

  always #5 clk = ~clk;

  wrr_bus_scheduler #(
    .N_REQ   (N_REQ),
    .WGT_W   (WGT_W),
    .DEF_WGT (1),
    .TMO_W   (TMO_W)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .req_i        (req_i),
    .end_txn_i    (end_txn_i),
    .cfg_load_i   (cfg_load_i),
    .weight_cfg_i (weight_cfg_i),
    .tmo_limit_i  (tmo_limit_i),
    .grant_o      (grant_o),
    .grant_id_o   (grant_id_o),
    .busy_o       (busy_o),
    .tmo_event_o  (tmo_event_o)
  );

  // Scoreboard consumer: every rising grant must match the next queued id.
  always @(negedge clk) begin
    if (grant_o !== '0 && prev_grant === '0) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_grant: got grant=%b id=%0d, required no grant", grant_o, grant_id_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (grant_o !== (4'b0001 << mon_e) || grant_id_o !== 2'(mon_e))
          $display("FAIL grant_order: got grant=%b id=%0d, required grant=%b id=%0d",
                   grant_o, grant_id_o, 4'b0001 << mon_e, mon_e);
        else
          n_pass++;
      end
    end
    prev_grant = grant_o;
  end

  task automatic do_reset();
    req_i        = '0;
    end_txn_i    = '0;
    cfg_load_i   = 1'b0;
    weight_cfg_i = '0;
    tmo_limit_i  = '0;
    rstb         = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
  endtask

  // Serve n grants: end_txn two cycles after each grant; optionally drop req with the last end.
  task automatic serve_grants(input int n, input bit drop_last);
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (grant_o === '0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      n_total++;
      if (grant_o === '0) $display("FAIL grant_timeout: got no grant after %0d cycles, required grant #%0d", t, k);
      else n_pass++;
      repeat (2) @(negedge clk);
      end_txn_i = grant_o;
      if (drop_last && k == n - 1) req_i = '0;
      @(negedge clk);
      end_txn_i = '0;
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    @(negedge clk);
    n_total += 4;
    if (grant_o !== 4'b0000) $display("FAIL reset_grant: got %b, required 0000", grant_o); else n_pass++;
    if (grant_id_o !== 2'd0) $display("FAIL reset_grant_id: got %0d, required 0", grant_id_o); else n_pass++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy_o); else n_pass++;
    if (tmo_event_o !== 1'b0) $display("FAIL reset_tmo_event: got %b, required 0", tmo_event_o); else n_pass++;
    do_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if (busy_o !== 1'b0) $display("FAIL idle_no_req: got busy=%b, required 0", busy_o); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    req_i = 4'b1111;
    @(negedge clk);
    n_total++;
    if (grant_o !== 4'b0001) $display("FAIL rr_first_latency: got %b, required 0001", grant_o); else n_pass++;
    serve_grants(4, 1'b0);
    // Released; all credits spent, so one reload cycle precedes the next grant.
    n_total++;
    if (grant_o !== 4'b0000) $display("FAIL rr_release: got %b, required 0000", grant_o); else n_pass++;
    @(negedge clk);
    n_total++;
    if (grant_o !== 4'b0000) $display("FAIL rr_reload_cycle: got %b, required 0000", grant_o); else n_pass++;
    @(negedge clk);
    n_total++;
    if (grant_o !== 4'b0001) $display("FAIL rr_after_reload: got %b, required 0001", grant_o); else n_pass++;
    serve_grants(1, 1'b1);
  endtask

  task automatic test_weighted();
    do_reset();
    cfg_load_i   = 1'b1;
    weight_cfg_i = 16'h0013;   // w0=3, w1=1, w2=w3=0
    @(negedge clk);
    cfg_load_i = 1'b0;
    // First round runs on reset credits (1 each), then 3:1 rounds from the last-served point.
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
    req_i = 4'b0011;
    serve_grants(8, 1'b1);
    // Weight-0 requester alone: never granted.
    req_i = 4'b0100;
    repeat (6) @(negedge clk);
    n_total++;
    if (busy_o !== 1'b0 || grant_o !== 4'b0000)
      $display("FAIL weight0_never_granted: got grant=%b busy=%b, required 0000/0", grant_o, busy_o);
    else n_pass++;
    req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back(0);
    req_i = 4'b0001;
    @(negedge clk);
    n_total++;
    if (grant_o !== 4'b0001) $display("FAIL b2b_first: got %b, required 0001", grant_o); else n_pass++;
    exp_q.push_back(1);
    req_i     = 4'b0011;
    end_txn_i = 4'b0001;
    @(negedge clk);
    end_txn_i = '0;
    n_total++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0)
      $display("FAIL b2b_gap: got grant=%b busy=%b, required 0000/0", grant_o, busy_o);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (grant_o !== 4'b0010) $display("FAIL b2b_second: got %b, required 0010", grant_o); else n_pass++;
    req_i     = '0;
    end_txn_i = 4'b0010;
    @(negedge clk);
    end_txn_i = '0;
  endtask

  task automatic test_ignore_end();
    do_reset();
    exp_q.push_back(0);
    req_i = 4'b0001;
    @(negedge clk);
    req_i     = '0;
    end_txn_i = 4'b0100;
    @(negedge clk);
    end_txn_i = '0;
    n_total++;
    if (grant_o !== 4'b0001) $display("FAIL foreign_end_ignored: got %b, required 0001", grant_o); else n_pass++;
    @(negedge clk);
    n_total++;
    if (grant_o !== 4'b0001 || busy_o !== 1'b1)
      $display("FAIL req_drop_held: got grant=%b busy=%b, required 0001/1", grant_o, busy_o);
    else n_pass++;
    end_txn_i = 4'b0001;
    @(negedge clk);
    end_txn_i = '0;
    n_total++;
    if (grant_o !== 4'b0000) $display("FAIL own_end_release: got %b, required 0000", grant_o); else n_pass++;
  endtask

  task automatic test_watchdog();
    int cnt;
    do_reset();
    tmo_limit_i = 8'd5;
    exp_q.push_back(0);
    req_i = 4'b0001;
    @(negedge clk);
    req_i = '0;
    cnt = 0;
    while (grant_o === 4'b0001 && cnt < 30) begin
      cnt++;
      @(negedge clk);
    end
`ifdef WRR_WATCHDOG_EN
    n_total += 3;
    if (cnt !== 5) $display("FAIL tmo_grant_cycles: got %0d, required 5", cnt); else n_pass++;
    if (tmo_event_o !== 1'b1) $display("FAIL tmo_event_pulse: got %b, required 1", tmo_event_o); else n_pass++;
    @(negedge clk);
    if (tmo_event_o !== 1'b0) $display("FAIL tmo_event_width: got %b, required 0", tmo_event_o); else n_pass++;
`else
    n_total += 2;
    if (cnt !== 30) $display("FAIL no_watchdog_hold: got %0d cycles, required 30", cnt); else n_pass++;
    if (tmo_event_o !== 1'b0) $display("FAIL no_watchdog_event: got %b, required 0", tmo_event_o); else n_pass++;
    end_txn_i = 4'b0001;
    @(negedge clk);
    end_txn_i = '0;
`endif
    tmo_limit_i = '0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    exp_q.push_back(2);
    req_i = 4'b0100;
    @(negedge clk);
    n_total++;
    if (grant_o !== 4'b0100) $display("FAIL ares_pre: got %b, required 0100", grant_o); else n_pass++;
    #2 rstb = 1'b0;
    #1;
    n_total += 2;
    if (grant_o !== 4'b0000) $display("FAIL ares_grant: got %b, required 0000", grant_o); else n_pass++;
    if (busy_o !== 1'b0) $display("FAIL ares_busy: got %b, required 0", busy_o); else n_pass++;
    req_i = '0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    exp_q.push_back(0);
    req_i = 4'b0101;
    @(negedge clk);
    n_total++;
    if (grant_o !== 4'b0001) $display("FAIL ares_priority: got %b, required 0001", grant_o); else n_pass++;
    req_i     = '0;
    end_txn_i = 4'b0001;
    @(negedge clk);
    end_txn_i = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_weighted();
    test_back_to_back();
    test_ignore_end();
    test_watchdog();
    test_async_reset();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending grants, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
